// File: rtl/wwdg_refresh_ctrl.sv
// Wishbone master that configures, arms and services a window watchdog slave.
// Refreshes only inside the open window and only when a heartbeat was seen since the last refresh.
module wwdg_refresh_ctrl #(
    parameter logic [31:0]  BASE_ADR    = 32'h0110_0000,
    parameter int           DAT_W       = 10,
    parameter logic [DAT_W-1:0] CFG_VAL = 10'h2D0,
    parameter logic [6:0]   RELOAD      = 7'h7F,
    parameter int           POLL_CYCLES = 16,
    parameter int           ACK_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             heartbeat,
    output logic [31:0]      adr_m2s,
    output logic [DAT_W-1:0] dat_m2s,
    output logic             cyc_m2s,
    output logic             stb_m2s,
    output logic             we_m2s,
    input  logic [DAT_W-1:0] dat_s2m,
    input  logic             ack_s2m,
    output logic             armed,
    output logic [7:0]       refresh_cnt,
    output logic             missed,
    output logic             expired,
    output logic             bus_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CFG_WR = 3'd1;
    localparam logic [2:0] ARM_WR = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] CR_RD  = 3'd4;
    localparam logic [2:0] EVAL   = 3'd5;
    localparam logic [2:0] REF_WR = 3'd6;
    localparam logic [2:0] FAULT  = 3'd7;

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    localparam logic [31:0]      CR_ADR   = BASE_ADR;
    localparam logic [31:0]      CFG_ADR  = BASE_ADR + 32'h4;
    localparam logic [DAT_W-1:0] CR_WDATA = {{(DAT_W-8){1'b0}}, 1'b1, RELOAD};
    localparam logic [6:0]       WIN      = CFG_VAL[6:0];

    logic [2:0]       state;
    logic [PW-1:0]    poll_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [7:0]       cr_q;
    logic             hb_pending;
    logic [31:0]      tgt_adr;
    logic [DAT_W-1:0] tgt_dat;
    logic             tgt_we;
    logic             unused_rd_hi;

    // The slave's CR is 8 bits wide; higher read bits carry nothing.
    assign unused_rd_hi = &{1'b0, dat_s2m[DAT_W-1:8]};
    assign stb_m2s      = cyc_m2s;

    always_comb begin
        tgt_adr = CR_ADR;
        tgt_dat = '0;
        tgt_we  = 1'b0;
        case (state)
            CFG_WR: begin
                tgt_adr = CFG_ADR;
                tgt_dat = CFG_VAL;
                tgt_we  = 1'b1;
            end
            ARM_WR, REF_WR: begin
                tgt_dat = CR_WDATA;
                tgt_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            poll_cnt    <= '0;
            tmo_cnt     <= '0;
            cr_q        <= '0;
            hb_pending  <= 1'b0;
            adr_m2s     <= '0;
            dat_m2s     <= '0;
            cyc_m2s     <= 1'b0;
            we_m2s      <= 1'b0;
            armed       <= 1'b0;
            refresh_cnt <= '0;
            missed      <= 1'b0;
            expired     <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if (state != WAIT) poll_cnt <= '0;

            case (state)
                IDLE: if (enable) state <= CFG_WR;

                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (poll_cnt == POLL_LAST) begin
                        state <= CR_RD;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end

                EVAL: begin
                    if (!cr_q[7]) begin
                        armed <= 1'b0;
                        state <= CFG_WR;
                    end else if (!cr_q[6]) begin
                        expired <= 1'b1;
                        state   <= WAIT;
                    end else if (cr_q[6:0] <= WIN) begin
                        if (hb_pending) begin
                            state <= REF_WR;
                        end else begin
                            missed <= 1'b1;
                            state  <= WAIT;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end

                FAULT: if (!enable) state <= IDLE;

                default: begin
                    // Bus states: one idle cycle on entry, then hold the cycle until ack or timeout.
                    if (!cyc_m2s) begin
                        if (!enable) begin
                            state <= IDLE;
                        end else begin
                            cyc_m2s <= 1'b1;
                            adr_m2s <= tgt_adr;
                            dat_m2s <= tgt_dat;
                            we_m2s  <= tgt_we;
                            tmo_cnt <= '0;
                        end
                    end else if (ack_s2m) begin
                        cyc_m2s <= 1'b0;
                        adr_m2s <= '0;
                        dat_m2s <= '0;
                        we_m2s  <= 1'b0;
                        case (state)
                            CFG_WR: state <= ARM_WR;
                            ARM_WR: begin
                                armed      <= 1'b1;
                                hb_pending <= 1'b0;
                                state      <= WAIT;
                            end
                            CR_RD: begin
                                cr_q  <= dat_s2m[7:0];
                                state <= EVAL;
                            end
                            default: begin
                                refresh_cnt <= refresh_cnt + 8'd1;
                                hb_pending  <= 1'b0;
                                state       <= WAIT;
                            end
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        cyc_m2s <= 1'b0;
                        adr_m2s <= '0;
                        dat_m2s <= '0;
                        we_m2s  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase

            // A heartbeat in the same cycle as a clear must survive.
            if (heartbeat) hb_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wwdg_refresh_ctrl.sv
// Directed bench for wwdg_refresh_ctrl with a small wishbone slave that acks two cycles after cyc rises.
module tb_wwdg_refresh_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        heartbeat;
    logic [31:0] adr_m2s;
    logic [9:0]  dat_m2s;
    logic        cyc_m2s;
    logic        stb_m2s;
    logic        we_m2s;
    logic [9:0]  dat_s2m;
    logic        ack_s2m = 1'b0;
    logic        armed;
    logic [7:0]  refresh_cnt;
    logic        missed;
    logic        expired;
    logic        bus_err;

    logic [7:0]  cr_val;
    logic        no_ack;
    int          scnt = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [31:0] wr_adr [0:63];
    logic [9:0]  wr_dat [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign dat_s2m = {2'b00, cr_val};

    wwdg_refresh_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .heartbeat   (heartbeat),
        .adr_m2s     (adr_m2s),
        .dat_m2s     (dat_m2s),
        .cyc_m2s     (cyc_m2s),
        .stb_m2s     (stb_m2s),
        .we_m2s      (we_m2s),
        .dat_s2m     (dat_s2m),
        .ack_s2m     (ack_s2m),
        .armed       (armed),
        .refresh_cnt (refresh_cnt),
        .missed      (missed),
        .expired     (expired),
        .bus_err     (bus_err)
    );

    // Slave model and transaction log
    always @(posedge clk) begin
        if (!cyc_m2s) begin
            scnt    <= 0;
            ack_s2m <= 1'b0;
        end else if (ack_s2m) begin
            ack_s2m <= 1'b0;
            scnt    <= 0;
            if (we_m2s) begin
                wr_adr[wr_count % 64] <= adr_m2s;
                wr_dat[wr_count % 64] <= dat_m2s;
                wr_count <= wr_count + 1;
            end else begin
                rd_count <= rd_count + 1;
            end
        end else if (!no_ack) begin
            if (scnt == 1) ack_s2m <= 1'b1;
            scnt <= scnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_read(input string tag);
        int target;
        target = rd_count + 1;
        for (int i = 0; i < 200 && rd_count < target; i++) @(negedge clk);
        check(tag, 32'(rd_count >= target), 32'd1);
        cycles(8);
    endtask

    task automatic pulse_hb;
        heartbeat = 1'b1;
        @(negedge clk);
        heartbeat = 1'b0;
    endtask

    initial begin
        int          wbase;
        int          ncyc;
        logic [31:0] tmo_adr;

        rst       = 1'b0;
        enable    = 1'b0;
        heartbeat = 1'b0;
        no_ack    = 1'b0;
        cr_val    = 8'hD1;
        cycles(3);
        check("rst_cyc", 32'(cyc_m2s), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_cnt", 32'(refresh_cnt), 32'd0);
        check("rst_flags", {29'd0, missed, expired, bus_err}, 32'd0);
        rst = 1'b1;
        cycles(2);

        // T1 boot: CFG write then CR arm write
        enable = 1'b1;
        for (int i = 0; i < 100 && wr_count < 2; i++) @(negedge clk);
        cycles(2);
        check("boot_wr_count", 32'(wr_count), 32'd2);
        check("boot_cfg_adr", wr_adr[0], 32'h0110_0004);
        check("boot_cfg_dat", 32'(wr_dat[0]), 32'h2D0);
        check("boot_cr_adr", wr_adr[1], 32'h0110_0000);
        check("boot_cr_dat", 32'(wr_dat[1]), 32'h0FF);
        check("boot_armed", 32'(armed), 32'd1);

        // T2 window: closed window (c=0x51) with heartbeat pending -> no write
        pulse_hb();
        wait_read("t2_read_closed");
        check("t2_closed_wr", 32'(wr_count), 32'd2);
        check("t2_closed_missed", 32'(missed), 32'd0);
        check("t2_closed_cnt", 32'(refresh_cnt), 32'd0);

        // boundary c==win is open; heartbeat still pending -> refresh
        cr_val = 8'hD0;
        wait_read("t2_read_edge");
        check("t2_edge_wr", 32'(wr_count), 32'd3);
        check("t2_edge_adr", wr_adr[2], 32'h0110_0000);
        check("t2_edge_dat", 32'(wr_dat[2]), 32'h0FF);
        check("t2_edge_cnt", 32'(refresh_cnt), 32'd1);

        cr_val = 8'hCF;
        pulse_hb();
        wait_read("t2_read_cf");
        check("t2_cf_wr", 32'(wr_count), 32'd4);
        check("t2_cf_cnt", 32'(refresh_cnt), 32'd2);
        check("t2_cf_missed", 32'(missed), 32'd0);

        // T3 no heartbeat in open window, then expired counter
        cr_val = 8'hC5;
        wait_read("t3_read_c5");
        check("t3_c5_wr", 32'(wr_count), 32'd4);
        check("t3_c5_missed", 32'(missed), 32'd1);
        check("t3_c5_expired", 32'(expired), 32'd0);
        cr_val = 8'hBF;
        wait_read("t3_read_bf");
        check("t3_bf_expired", 32'(expired), 32'd1);
        check("t3_bf_wr", 32'(wr_count), 32'd4);
        check("t3_bf_cnt", 32'(refresh_cnt), 32'd2);

        // T5 heartbeat coincides with the refresh ack
        cr_val = 8'hC0;
        pulse_hb();
        ncyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc_m2s && we_m2s && ack_s2m) begin
                ncyc = 1;
                break;
            end
        end
        check("t5_found_ack", 32'(ncyc), 32'd1);
        pulse_hb();
        cycles(4);
        check("t5_cnt_a", 32'(refresh_cnt), 32'd3);
        wbase = wr_count;
        wait_read("t5_read_next");
        check("t5_wr_again", 32'(wr_count - wbase), 32'd1);
        check("t5_cnt_b", 32'(refresh_cnt), 32'd4);

        // T6 async reset during a CR read
        ncyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc_m2s && !we_m2s) begin
                ncyc = 1;
                break;
            end
        end
        check("t6_found_rd", 32'(ncyc), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_cyc", {30'd0, cyc_m2s, stb_m2s}, 32'd0);
        check("t6_adr", adr_m2s, 32'd0);
        check("t6_armed", 32'(armed), 32'd0);
        check("t6_cnt", 32'(refresh_cnt), 32'd0);
        check("t6_flags", {29'd0, missed, expired, bus_err}, 32'd0);

        // T4 ack timeout on the CFG write
        no_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        ncyc    = 0;
        tmo_adr = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc_m2s) begin
                ncyc++;
                tmo_adr = adr_m2s;
            end else if (ncyc > 0) begin
                break;
            end
        end
        check("t4_cyc_len", 32'(ncyc), 32'd8);
        check("t4_adr", tmo_adr, 32'h0110_0004);
        check("t4_bus_err", 32'(bus_err), 32'd1);
        ncyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cyc_m2s) ncyc++;
        end
        check("t4_fault_idle", 32'(ncyc), 32'd0);
        enable = 1'b0;
        no_ack = 1'b0;
        cycles(3);
        enable = 1'b1;
        wbase  = wr_count;
        for (int i = 0; i < 100 && wr_count < wbase + 2; i++) @(negedge clk);
        cycles(2);
        check("t4_reboot_wr", 32'(wr_count - wbase), 32'd2);
        check("t4_reboot_armed", 32'(armed), 32'd1);
        check("t4_bus_err_sticky", 32'(bus_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
